// File: rtl/bf16_pkg.sv
// Shared types and constants for the BF16 divider.
// FSM states, BF16 encodings and field widths.
package bf16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_t;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam int          BF16_BIAS = 127;
  localparam int          EXP_W     = 8;
  localparam int          MAN_W     = 7;
  localparam int          SIG_W     = MAN_W + 1;

endpackage

// File: rtl/bf16_mant_div_iter.sv
// Restoring mantissa divider: q = floor((ma << (STEPS-1)) / mb).
// One quotient bit per cycle, MSB first; remainder kept.
module bf16_mant_div_iter
  import bf16_pkg::*;
#(
  parameter int STEPS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] ma,
  input  logic [SIG_W-1:0] mb,
  output logic             done,
  output logic [STEPS-1:0] q,
  output logic [SIG_W-1:0] rem
);

  localparam int CW = $clog2(STEPS + 1);

  logic [SIG_W-1:0] dvs;
  logic             nbit;
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [SIG_W:0]   trial;
  logic [SIG_W:0]   diff;
  logic             ge;

  // First trial must equal ma, so seed rem=ma>>1 and shift ma[0] in.
  always_comb begin
    trial = {rem, nbit};
    diff  = trial - {1'b0, dvs};
    ge    = trial >= {1'b0, dvs};
    done  = busy && (cnt == CW'(STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      q    <= '0;
      dvs  <= '0;
      nbit <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= {1'b0, ma[SIG_W-1:1]};
      nbit <= ma[0];
      dvs  <= mb;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= ge ? diff[SIG_W-1:0] : trial[SIG_W-1:0];
      q    <= {q[STEPS-2:0], ge};
      nbit <= 1'b0;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/bf16_divider.sv
// BF16 divider: special-case bypass, serial mantissa
// division, normalize and round-to-nearest-even.
module bf16_divider
  import bf16_pkg::*;
#(
  parameter int DATA_TYPE = 16,
  parameter int DIV_STEPS = 10
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_TYPE-1:0] A,
  input  logic [DATA_TYPE-1:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_TYPE-1:0] O
);

  localparam int QW = DIV_STEPS;
  localparam logic signed [9:0] BIAS_S = 10'(BF16_BIAS);

  state_t           state;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic             start;
  logic             sign;
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  logic             special;
  logic [15:0]      sval;
  logic [15:0]      nval;
  logic             div_done;
  logic [QW-1:0]    q;
  logic [SIG_W-1:0] rem;
  logic [SIG_W-1:0] mant;
  logic [SIG_W-1:0] mant_r;
  logic             guard, sticky, inc;
  logic [SIG_W:0]   sum;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;

  always_comb begin
    sign   = a_q[15] ^ b_q[15];
    ea     = a_q[14:7];
    eb     = b_q[14:7];
    a_zero = ea == '0;
    b_zero = eb == '0;
    a_inf  = (ea == '1) && (a_q[6:0] == '0);
    b_inf  = (eb == '1) && (b_q[6:0] == '0);
    a_nan  = (ea == '1) && (a_q[6:0] != '0);
    b_nan  = (eb == '1) && (b_q[6:0] != '0);
    special = 1'b1;
    sval    = '0;
    if (a_nan || b_nan || (a_zero && b_zero) ||
        (a_inf && b_inf))
      sval = BF16_QNAN;
    else if (b_zero)
      sval = BF16_PINF | {sign, 15'h0};
    else if (a_zero)
      sval = {sign, 15'h0};
    else if (a_inf)
      sval = BF16_PINF | {sign, 15'h0};
    else if (b_inf)
      sval = {sign, 15'h0};
    else
      special = 1'b0;
  end

  // q[QW-1] tells whether ma >= mb, i.e. which bits hold the significand.
  always_comb begin
    if (q[QW-1]) begin
      mant   = q[QW-1:QW-8];
      guard  = q[QW-9];
      sticky = (|q[QW-10:0]) | (|rem);
      exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + BIAS_S;
    end else begin
      mant   = q[QW-2:QW-9];
      guard  = q[QW-10];
      sticky = |rem;
      exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + BIAS_S - 10'sd1;
    end
    inc = guard & (sticky | mant[0]);
    sum = {1'b0, mant} + {{SIG_W{1'b0}}, inc};
    if (sum[SIG_W]) begin
      mant_r = 8'h80;
      exp_r  = exp_n + 10'sd1;
    end else begin
      mant_r = sum[SIG_W-1:0];
      exp_r  = exp_n;
    end
    if (exp_r >= 10'sd255)
      nval = BF16_PINF | {sign, 15'h0};
    else if (exp_r <= 10'sd0)
      nval = {sign, 15'h0};
    else
      nval = {sign, exp_r[7:0], mant_r[6:0]};
  end

  bf16_mant_div_iter #(
    .STEPS(DIV_STEPS)
  ) u_iter (
    .clk  (CLK),
    .rst_n(rst_n),
    .start(start && !special),
    .ma   ({1'b1, a_q[6:0]}),
    .mb   ({1'b1, b_q[6:0]}),
    .done (div_done),
    .q    (q),
    .rem  (rem)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      start     <= 1'b0;
      O         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            in_ready <= 1'b0;
            start    <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          if (start && special) begin
            O         <= sval;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (div_done) begin
            state <= NORM;
          end
        end
        NORM: begin
          O         <= nval;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
